// File: rtl/data_ram_responder.sv
// Single-port data RAM that answers one load/store at a time through an
// IDLE -> WAIT -> ACCESS -> RESP handshake with a configurable access delay.
module data_ram_responder #(
    parameter int DATA_DBUS_WIDTH = 32,
    parameter int ADDR_DBUS_WIDTH = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int WAIT_STATES     = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [ADDR_DBUS_WIDTH-1:0]   i_addr,
    input  logic                         i_we,
    input  logic [DATA_DBUS_WIDTH-1:0]   i_wdata,
    input  logic [DATA_DBUS_WIDTH/8-1:0] i_be,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic [DATA_DBUS_WIDTH-1:0]   o_rdata,
    output logic                         o_rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int BE_W  = DATA_DBUS_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   wait_cnt_q, wait_cnt_d;
    logic                         ready_q, ready_d;
    logic [ADDR_DBUS_WIDTH-1:0]   addr_q, addr_d;
    logic                         we_q, we_d;
    logic [DATA_DBUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]              be_q, be_d;

    logic [DATA_DBUS_WIDTH-1:0]   mem [DEPTH_WORDS];
    logic [DATA_DBUS_WIDTH-1:0]   mem_rdata_q;
    logic [IDX_W-1:0]             word_idx;
    logic                         fault;
    logic                         accept;
    logic [BE_W-1:0]              lane_we;

    // ready_q is held low through reset so the requester only sees ready
    // from the first clock edge after reset release.
    assign accept   = (state_q == ST_IDLE) && ready_q && i_req_valid;
    assign word_idx = addr_q[IDX_W+1:2];
    assign fault    = (addr_q[1:0] != 2'b00) || ((addr_q >> (IDX_W + 2)) != '0);

    // State and request-latch registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture happens only on accept; later port activity is ignored.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (accept) begin
            addr_d  = i_addr;
            we_d    = i_we;
            wdata_d = i_wdata;
            be_d    = i_be;
        end
    end

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        assign lane_we[gi] = (state_q == ST_ACCESS) && we_q && !fault && be_q[gi];
    end

    // Array with registered read; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (lane_we[b]) begin
                mem[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
        if (state_q == ST_ACCESS) begin
            mem_rdata_q <= mem[word_idx];
        end
    end

    // Outputs
    always_comb begin
        o_req_ready = ready_q;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rdata     = '0;
        if (state_q == ST_RESP) begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = fault;
            if (!we_q && !fault) begin
                o_rdata = mem_rdata_q;
            end
        end
    end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter DATA_DBUS_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_DBUS_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, number of data words in the array, power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra access cycles, range 0-15.
REQ-005 SHALL have port i_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_req_valid  in  1  requester presents a load/store.
REQ-008 SHALL have port o_req_ready  out  1  responder can accept a request.
REQ-009 SHALL have port i_addr  in  ADDR_DBUS_WIDTH  byte address, from the execute-stage ALU result.
REQ-010 SHALL have port i_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port i_wdata  in  DATA_DBUS_WIDTH  store data.
REQ-012 SHALL have port i_be  in  DATA_DBUS_WIDTH/8  byte-lane enables for stores.
REQ-013 SHALL have port o_rsp_valid  out  1  response present.
REQ-014 SHALL have port i_rsp_ready  in  1  requester consumes the response.
REQ-015 SHALL have port o_rdata  out  DATA_DBUS_WIDTH  load data.
REQ-016 SHALL have port o_rsp_err  out  1  access fault flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-018 SHALL drive o_req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on an edge with i_req_valid=1 and o_req_ready=1, latching i_addr, i_we, i_wdata, i_be.
REQ-020 SHALL go IDLE->WAIT on accept with WAIT_STATES>0, loading the wait counter with WAIT_STATES-1; with WAIT_STATES=0 SHALL go IDLE->ACCESS.
REQ-021 SHALL stay in WAIT while the counter is nonzero, decrementing it each cycle, and go to ACCESS on the edge where it is 0.
REQ-022 SHALL perform the array access in ACCESS and go to RESP on the next edge, so o_rsp_valid rises exactly WAIT_STATES+1 edges after the accepting edge.
REQ-023 SHALL use word index addr[log2(DEPTH_WORDS)+1:2] for the array.
REQ-024 SHALL fault when addr[1:0]!=0 or addr>=4*DEPTH_WORDS; on fault: no array change, o_rdata=0, o_rsp_err=1.
REQ-025 SHALL, on a store, write only the byte lanes with i_be bit set; i_be=0 SHALL leave memory unchanged but still respond.
REQ-026 SHALL, on a load, return the full word irrespective of i_be; on a store o_rdata SHALL be 0.
REQ-027 SHALL hold o_rsp_valid, o_rdata and o_rsp_err stable in RESP until an edge with i_rsp_ready=1, then go to IDLE.
REQ-028 SHALL NOT accept a new request in the RESP cycle even if i_rsp_ready=1 (one idle cycle between transactions).
REQ-029 SHALL ignore i_req_valid and request-port inputs outside IDLE; changes there SHALL not affect the transaction in flight.
REQ-030 SHALL drive o_rsp_valid=0, o_rsp_err=0 and o_rdata=0 outside RESP.

Reset
REQ-031 SHALL, while i_rst=0, force state IDLE, wait counter 0, o_rsp_valid=0, o_rsp_err=0, o_rdata=0, o_req_ready=0.
REQ-032 SHALL drive o_req_ready=1 from the first edge after i_rst deasserts.
REQ-033 SHALL abort any transaction on reset; a store asserted before ACCESS SHALL not modify the array; array contents SHALL not be reset.

Verification
REQ-034 SHALL verify: WAIT_STATES=1, store addr 0x10 data 0xDEADBEEF be=0xF, then load 0x10 -> rsp_valid 2 edges after each accept, load rdata 0xDEADBEEF, err=0.
REQ-035 SHALL verify: store 0x10 data 0x000000AA be=0x1 over 0xDEADBEEF -> load returns 0xDEADBEAA.
REQ-036 SHALL verify: load 0x12 and load 4*DEPTH_WORDS -> err=1, rdata=0; prior contents of 0x10 unchanged.
REQ-037 SHALL verify: response backpressure, i_rsp_ready=0 for 5 cycles -> rsp_valid, rdata, err constant; o_req_ready=0 throughout; IDLE one edge after i_rsp_ready=1.
REQ-038 SHALL verify: i_rst pulsed low during WAIT of store 0x20 data 0x12345678 -> outputs reset immediately; later load 0x20 returns the pre-store value.
REQ-039 SHALL verify: WAIT_STATES=0 -> rsp_valid 1 edge after accept; back-to-back requests accepted every 3 cycles with i_rsp_ready=1.
